// File: rtl/pipelined_ram_if.sv
// Request/response bus for pipelined_ram: byte-addressed stores and loads in,
// valid/ready load results out, plus error flag and outstanding-load count.
interface pipelined_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   addressIn;
  logic [DATA_WIDTH-1:0]   dataWriteIn;
  logic [DATA_WIDTH/8-1:0] byteSelect;
  logic                    store;
  logic                    load;
  logic                    requestReady;
  logic [DATA_WIDTH-1:0]   dataReadOut;
  logic                    readValid;
  logic                    readReady;
  logic                    addressOutOfRange;
  logic [2:0]              loadsInFlight;

  modport master (
    output addressIn, dataWriteIn, byteSelect, store, load, readReady,
    input  requestReady, dataReadOut, readValid, addressOutOfRange, loadsInFlight
  );

  modport slave (
    input  addressIn, dataWriteIn, byteSelect, store, load, readReady,
    output requestReady, dataReadOut, readValid, addressOutOfRange, loadsInFlight
  );
endinterface

// File: rtl/pipelined_ram.sv
// Byte-enabled word RAM with a fixed-latency, stallable load pipeline and
// out-of-range reporting for both stores and loads.
module pipelined_ram #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input logic            clk,
  input logic            reset,
  pipelined_ram_if.slave bus
);

  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int OFFSET_BITS = $clog2(BYTES);
  localparam int INDEX_BITS  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH_WORDS) * 64'(BYTES);

  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

  logic [READ_LATENCY-1:0] stageValid;
  logic [READ_LATENCY-1:0] stageOor;
  logic [DATA_WIDTH-1:0]   stageData [READ_LATENCY];

  logic                    readValidQ;
  logic                    stall;
  logic                    requestAccept;
  logic                    storeAccept;
  logic                    loadAccept;
  logic                    outConsume;
  logic                    addrInRange;
  logic [INDEX_BITS-1:0]   wordIndex;
  logic                    storeOorPulse;
  logic [2:0]              inFlight;

  assign wordIndex   = INDEX_BITS'(bus.addressIn >> OFFSET_BITS);
  assign addrInRange = (64'(bus.addressIn) < BYTE_LIMIT);

  // A held result with no consumer freezes the whole read path and blocks new requests.
  assign readValidQ       = stageValid[READ_LATENCY-1];
  assign stall            = readValidQ && !bus.readReady;
  assign bus.requestReady = reset && !stall;
  assign requestAccept    = (bus.store || bus.load) && bus.requestReady;
  assign storeAccept      = requestAccept && bus.store;
  assign loadAccept       = requestAccept && bus.load && !bus.store;
  assign outConsume       = readValidQ && bus.readReady;

  // Storage has no reset so contents survive reset assertion.
  always_ff @(posedge clk) begin
    if (storeAccept && addrInRange) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.byteSelect[b]) begin
          mem[wordIndex][b*8 +: 8] <= bus.dataWriteIn[b*8 +: 8];
        end
      end
    end
  end

  // Stage 0 captures the word at the acceptance edge; out-of-range loads carry zero data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stageValid <= '0;
      stageOor   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        stageData[i] <= '0;
      end
    end else if (!stall) begin
      stageValid[0] <= loadAccept;
      stageOor[0]   <= loadAccept && !addrInRange;
      stageData[0]  <= (loadAccept && addrInRange) ? mem[wordIndex] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        stageValid[i] <= stageValid[i-1];
        stageOor[i]   <= stageOor[i-1];
        stageData[i]  <= stageData[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      storeOorPulse <= 1'b0;
    end else begin
      storeOorPulse <= storeAccept && !addrInRange;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inFlight <= 3'd0;
    end else begin
      case ({loadAccept, outConsume})
        2'b10:   inFlight <= inFlight + 3'd1;
        2'b01:   inFlight <= inFlight - 3'd1;
        default: inFlight <= inFlight;
      endcase
    end
  end

  assign bus.readValid         = readValidQ;
  assign bus.dataReadOut       = stageData[READ_LATENCY-1];
  assign bus.addressOutOfRange = storeOorPulse || (readValidQ && stageOor[READ_LATENCY-1]);
  assign bus.loadsInFlight     = inFlight;

endmodule

// File: tb/tb_pipelined_ram.sv
// Self-checking bench for pipelined_ram: directed scenarios plus randomized
// traffic against a byte-level memory model and a queue of pending loads.
module tb_pipelined_ram;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipelined_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  pipelined_ram #(
    .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    bit          oor;
    bit          known;
    int          remaining;
  } pend_t;

  // Each pending load counts down the cycles until it reaches the output;
  // the countdown freezes whenever the consumer holds off a visible result.
  pend_t       pend [$];
  logic [7:0]  memModel [logic [31:0]];
  bit          storeOorQ;
  bit          mValid, mReady, mOor, mStall, mKnown;
  logic [31:0] mData;
  int          mInflight;

  function automatic void evalModel();
    mValid    = (pend.size() > 0) && (pend[0].remaining == 0);
    mData     = mValid ? pend[0].data : 32'h0;
    mKnown    = mValid && pend[0].known;
    mStall    = mValid && !bus.readReady;
    mReady    = reset && !mStall;
    mOor      = storeOorQ || (mValid && pend[0].oor);
    mInflight = pend.size();
  endfunction

  function automatic void modelRead(input logic [31:0] addr, output logic [31:0] data,
                                    output bit known);
    logic [31:0] base;
    base  = {addr[31:2], 2'b00};
    data  = 32'h0;
    known = 1'b1;
    if (addr < LIMIT) begin
      for (int b = 0; b < 4; b++) begin
        if (memModel.exists(base + 32'(b))) data[b*8 +: 8] = memModel[base + 32'(b)];
        else known = 1'b0;
      end
    end
  endfunction

  task automatic drive(input bit st, input bit ld, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] sel, input bit rr);
    bus.store       = st;
    bus.load        = ld;
    bus.addressIn   = addr;
    bus.dataWriteIn = data;
    bus.byteSelect  = sel;
    bus.readReady   = rr;
  endtask

  task automatic settle();
    #2;
    evalModel();
  endtask

  task automatic tick();
    bit          accept, inRange;
    logic [31:0] base;
    pend_t       p;
    evalModel();
    if (!reset) begin
      pend.delete();
      storeOorQ = 1'b0;
    end else begin
      accept  = (bus.store || bus.load) && mReady;
      inRange = bus.addressIn < LIMIT;
      base    = {bus.addressIn[31:2], 2'b00};
      if (mValid && bus.readReady) void'(pend.pop_front());
      if (!mStall) foreach (pend[i]) if (pend[i].remaining > 0) pend[i].remaining--;
      if (accept && bus.store && inRange)
        for (int b = 0; b < 4; b++)
          if (bus.byteSelect[b]) memModel[base + 32'(b)] = bus.dataWriteIn[b*8 +: 8];
      if (accept && bus.load && !bus.store) begin
        modelRead(bus.addressIn, p.data, p.known);
        p.oor       = !inRange;
        p.remaining = LAT - 1;
        pend.push_back(p);
      end
      storeOorQ = accept && bus.store && !inRange;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 1);
    repeat (2) tick();
    settle();
    checks++; if (bus.readValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got=%0b exp=0", bus.readValid); end
    checks++; if (bus.dataReadOut !== 32'h0) begin errors++; $display("[TB] FAIL rst_data got=%h exp=0", bus.dataReadOut); end
    checks++; if (bus.addressOutOfRange !== 1'b0) begin errors++; $display("[TB] FAIL rst_oor got=%0b exp=0", bus.addressOutOfRange); end
    checks++; if (bus.loadsInFlight !== 3'd0) begin errors++; $display("[TB] FAIL rst_inflight got=%0d exp=0", bus.loadsInFlight); end
    checks++; if (bus.requestReady !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready got=%0b exp=0", bus.requestReady); end
    reset = 1'b1;
    tick();
    settle();
    checks++; if (bus.requestReady !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready got=%0b exp=1", bus.requestReady); end
  endtask

  task automatic test_store_load();
    drive(1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 1); settle(); tick();
    drive(0, 1, 32'h10, 0, 0, 1);               settle(); tick();
    drive(0, 0, 0, 0, 0, 1);                    settle();
    checks++; if (bus.readValid !== 1'b0) begin errors++; $display("[TB] FAIL sl_early_valid got=%0b exp=0", bus.readValid); end
    tick(); settle();
    checks++; if (bus.readValid !== 1'b1) begin errors++; $display("[TB] FAIL sl_valid got=%0b exp=1", bus.readValid); end
    checks++; if (bus.dataReadOut !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL sl_data got=%h exp=deadbeef", bus.dataReadOut); end
    tick();
    drive(1, 0, 32'h10, 32'h000000AA, 4'h1, 1); settle(); tick();
    drive(0, 1, 32'h13, 0, 0, 1);               settle(); tick();
    drive(0, 0, 0, 0, 0, 1);                    settle(); tick(); settle();
    checks++; if (bus.readValid !== 1'b1) begin errors++; $display("[TB] FAIL be_valid got=%0b exp=1", bus.readValid); end
    checks++; if (bus.dataReadOut !== 32'hDEADBEAA) begin errors++; $display("[TB] FAIL be_data got=%h exp=deadbeaa", bus.dataReadOut); end
    tick(); settle();
    checks++; if (bus.readValid !== 1'b0) begin errors++; $display("[TB] FAIL be_single got=%0b exp=0", bus.readValid); end
  endtask

  task automatic test_back_to_back_stall();
    logic [31:0] expVals [3];
    expVals[0] = 32'h11111111; expVals[1] = 32'h22222222; expVals[2] = 32'h33333333;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'(i * 4), expVals[i], 4'hF, 1); settle(); tick();
    end
    drive(0, 1, 32'h0, 0, 0, 0); settle(); tick();
    drive(0, 1, 32'h4, 0, 0, 0); settle(); tick();
    drive(0, 1, 32'h8, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++; if (bus.requestReady !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready c=%0d got=%0b exp=0", c, bus.requestReady); end
      checks++; if (bus.loadsInFlight !== 3'd2) begin errors++; $display("[TB] FAIL stall_inflight c=%0d got=%0d exp=2", c, bus.loadsInFlight); end
      checks++; if (bus.readValid !== 1'b1 || bus.dataReadOut !== expVals[0]) begin
        errors++; $display("[TB] FAIL stall_hold c=%0d got=%0b/%h exp=1/%h", c, bus.readValid, bus.dataReadOut, expVals[0]);
      end
      tick();
    end
    bus.readReady = 1'b1;
    settle();
    checks++; if (bus.requestReady !== 1'b1) begin errors++; $display("[TB] FAIL unstall_ready got=%0b exp=1", bus.requestReady); end
    for (int i = 0; i < 3; i++) begin
      if (i == 0) settle();
      checks++; if (bus.readValid !== 1'b1 || bus.dataReadOut !== expVals[i]) begin
        errors++; $display("[TB] FAIL drain_order i=%0d got=%0b/%h exp=1/%h", i, bus.readValid, bus.dataReadOut, expVals[i]);
      end
      tick();
      drive(0, 0, 0, 0, 0, 1);
      settle();
    end
    checks++; if (bus.loadsInFlight !== 3'd0) begin errors++; $display("[TB] FAIL drain_inflight got=%0d exp=0", bus.loadsInFlight); end
    checks++; if (bus.readValid !== 1'b0) begin errors++; $display("[TB] FAIL drain_valid got=%0b exp=0", bus.readValid); end
    tick();
  endtask

  task automatic test_out_of_range();
    drive(1, 0, 32'h1000, 32'hCAFEF00D, 4'hF, 1); settle();
    checks++; if (bus.addressOutOfRange !== 1'b0) begin errors++; $display("[TB] FAIL oors_early got=%0b exp=0", bus.addressOutOfRange); end
    tick();
    drive(0, 0, 0, 0, 0, 1); settle();
    checks++; if (bus.addressOutOfRange !== 1'b1) begin errors++; $display("[TB] FAIL oors_pulse got=%0b exp=1", bus.addressOutOfRange); end
    tick(); settle();
    checks++; if (bus.addressOutOfRange !== 1'b0) begin errors++; $display("[TB] FAIL oors_width got=%0b exp=0", bus.addressOutOfRange); end
    drive(0, 1, 32'h0, 0, 0, 1); settle(); tick();
    drive(0, 1, 32'h1000, 0, 0, 1); settle(); tick();
    drive(0, 0, 0, 0, 0, 1); settle();
    checks++; if (bus.dataReadOut !== 32'h11111111) begin errors++; $display("[TB] FAIL oors_nowrite got=%h exp=11111111", bus.dataReadOut); end
    tick(); settle();
    checks++; if (bus.readValid !== 1'b1 || bus.dataReadOut !== 32'h0 || bus.addressOutOfRange !== 1'b1) begin
      errors++; $display("[TB] FAIL oorl_result got=%0b/%h/%0b exp=1/0/1", bus.readValid, bus.dataReadOut, bus.addressOutOfRange);
    end
    tick(); settle();
    checks++; if (bus.addressOutOfRange !== 1'b0) begin errors++; $display("[TB] FAIL oorl_width got=%0b exp=0", bus.addressOutOfRange); end
    drive(1, 1, 32'h1000, 32'h5A5A5A5A, 4'hF, 1); settle(); tick();
    drive(0, 0, 0, 0, 0, 1); settle();
    checks++; if (bus.addressOutOfRange !== 1'b1 || bus.loadsInFlight !== 3'd0) begin
      errors++; $display("[TB] FAIL both_oor got=%0b/%0d exp=1/0", bus.addressOutOfRange, bus.loadsInFlight);
    end
    drive(1, 1, 32'h20, 32'h44444444, 4'hF, 1); settle(); tick();
    drive(0, 1, 32'h20, 0, 0, 1); settle(); tick();
    drive(0, 0, 0, 0, 0, 1); settle();
    checks++; if (bus.loadsInFlight !== 3'd1) begin errors++; $display("[TB] FAIL both_dropload got=%0d exp=1", bus.loadsInFlight); end
    tick(); settle();
    checks++; if (bus.dataReadOut !== 32'h44444444) begin errors++; $display("[TB] FAIL both_store got=%h exp=44444444", bus.dataReadOut); end
    tick();
  endtask

  task automatic test_reset_midflight();
    drive(0, 1, 32'h4, 0, 0, 1); settle(); tick();
    drive(0, 1, 32'h8, 0, 0, 1); settle(); tick();
    drive(0, 0, 0, 0, 0, 1); settle();
    checks++; if (bus.loadsInFlight !== 3'd2) begin errors++; $display("[TB] FAIL mid_inflight got=%0d exp=2", bus.loadsInFlight); end
    reset = 1'b0;
    #1;
    checks++; if (bus.readValid !== 1'b0 || bus.loadsInFlight !== 3'd0) begin
      errors++; $display("[TB] FAIL mid_async got=%0b/%0d exp=0/0", bus.readValid, bus.loadsInFlight);
    end
    repeat (2) tick();
    reset = 1'b1;
    settle();
    checks++; if (bus.requestReady !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready got=%0b exp=1", bus.requestReady); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (bus.readValid !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale c=%0d got=%0b exp=0", c, bus.readValid); end
      tick(); settle();
    end
    drive(0, 1, 32'h4, 0, 0, 1); settle(); tick();
    drive(0, 0, 0, 0, 0, 1); settle(); tick(); settle();
    checks++; if (bus.readValid !== 1'b1 || bus.dataReadOut !== 32'h22222222) begin
      errors++; $display("[TB] FAIL mid_retain got=%0b/%h exp=1/22222222", bus.readValid, bus.dataReadOut);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int          drainBudget;
    for (int w = 0; w < 16; w++) begin
      drive(1, 0, 32'(w * 4), $urandom(), 4'hF, 1); settle(); tick();
    end
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) addr = 32'h1000 | $urandom();
      else addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0, addr, $urandom(),
            4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      settle();
      checks++; if (bus.readValid !== mValid) begin errors++; $display("[TB] FAIL rnd_valid c=%0d got=%0b exp=%0b", c, bus.readValid, mValid); end
      if (mKnown) begin
        checks++; if (bus.dataReadOut !== mData) begin errors++; $display("[TB] FAIL rnd_data c=%0d got=%h exp=%h", c, bus.dataReadOut, mData); end
      end
      checks++; if (bus.requestReady !== mReady) begin errors++; $display("[TB] FAIL rnd_ready c=%0d got=%0b exp=%0b", c, bus.requestReady, mReady); end
      checks++; if (bus.addressOutOfRange !== mOor) begin errors++; $display("[TB] FAIL rnd_oor c=%0d got=%0b exp=%0b", c, bus.addressOutOfRange, mOor); end
      checks++; if (int'(bus.loadsInFlight) !== mInflight) begin errors++; $display("[TB] FAIL rnd_inflight c=%0d got=%0d exp=%0d", c, bus.loadsInFlight, mInflight); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 1);
    drainBudget = 20;
    settle();
    while (mInflight != 0 && drainBudget > 0) begin
      tick(); settle();
      drainBudget--;
    end
    checks++; if (bus.loadsInFlight !== 3'd0 || mInflight != 0) begin
      errors++; $display("[TB] FAIL rnd_drain got=%0d exp=0 model=%0d", bus.loadsInFlight, mInflight);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_store_load();
    test_back_to_back_stall();
    test_out_of_range();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
